data_writeback_associative_cache_controller: RTL and testbench

Miss-handling controller for the 2-way set-associative write-back data cache. It sits between the pipeline's memory stage and the cache memory array. It checks hits and serves read data and write hits in the same cycle. On a miss it stalls the pipeline, writes back a dirty victim block word-by-word over the external bus, refills the block, and then lets the access retry as a hit.

---
 rtl/data_writeback_associative_cache_controller_pkg.sv | 14 +
 rtl/data_writeback_associative_cache_controller.sv | 157 +++++++++++++++
 tb/tb_data_writeback_associative_cache_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_writeback_associative_cache_controller_pkg.sv
// Shared definitions for the data-cache miss controller: FSM state encoding
// and the address field offsets inside a 16-byte block.
package cache_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } cache_state_t;

    localparam int WORD_OFFSET  = 2;
    localparam int BLOCK_OFFSET = 4;

endpackage

// File: rtl/data_writeback_associative_cache_controller.sv
// Miss controller for the 2-way write-back data cache: same-cycle hits,
// word-serial victim writeback and block refill over the external bus.
module data_writeback_associative_cache_controller
    import cache_pkg::*;
#(
    parameter int lines     = 16384,
    parameter int setbits   = $clog2(lines),
    parameter int tagbits   = 14,
    parameter int blocksize = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        A,
    input  logic               MemRE,
    input  logic               MemWE,
    input  logic [31:0]        WD,
    input  logic [3:0]         ByteMask,
    output logic [31:0]        RD,
    output logic               Stall,
    input  logic               W1V,
    input  logic               W2V,
    input  logic               W1D,
    input  logic               W2D,
    input  logic               CurrLRU,
    input  logic [tagbits-1:0] W1Tag,
    input  logic [tagbits-1:0] W2Tag,
    input  logic [31:0]        W1RD,
    input  logic [31:0]        W2RD,
    output logic               W1WE,
    output logic               W2WE,
    output logic               DirtyIn,
    output logic [31:0]        CacheWD,
    output logic [31:0]        ANew,
    output logic [3:0]         ActiveByteMask,
    output logic [1:0]         CacheRDSel,
    output logic [31:0]        BusAdr,
    output logic [31:0]        BusWD,
    output logic               BusRE,
    output logic               BusWE,
    input  logic [31:0]        BusRD,
    input  logic               BusReady
);

    // Bus handshake: BusRE/BusWE act as valid and BusReady as ready; the strobe,
    // BusAdr and BusWD hold steady until a cycle with BusReady high completes
    // the beat, and BusRD is taken in that same cycle.

    cache_state_t state, state_next;
    logic [1:0]   cnt, cnt_next;
    logic         victim, victim_next;  // 0 = way1, 1 = way2

    logic [tagbits-1:0] tag;
    logic [setbits-1:0] set;
    logic               w1hit, w2hit, hit, req;
    logic               miss_victim, miss_victim_dirty;
    logic [tagbits-1:0] victim_tag;
    logic [31:0]        victim_rd;
    logic               last_beat;

    assign tag   = A[31:32-tagbits];
    assign set   = A[setbits+BLOCK_OFFSET-1:BLOCK_OFFSET];
    assign w1hit = W1V & (W1Tag == tag);
    assign w2hit = W2V & (W2Tag == tag);
    assign hit   = w1hit | w2hit;
    assign req   = MemRE | MemWE;

    // Fill an invalid way first; otherwise evict the least recently used one.
    assign miss_victim       = !W1V ? 1'b0 : (!W2V ? 1'b1 : !CurrLRU);
    assign miss_victim_dirty = miss_victim ? (W2V & W2D) : (W1V & W1D);

    assign victim_tag = victim ? W2Tag : W1Tag;
    assign victim_rd  = victim ? W2RD : W1RD;
    assign last_beat  = (cnt == 2'(blocksize - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= READY;
            cnt    <= 2'd0;
            victim <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            victim <= victim_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        victim_next    = victim;
        RD             = w1hit ? W1RD : W2RD;
        Stall          = 1'b0;
        W1WE           = 1'b0;
        W2WE           = 1'b0;
        DirtyIn        = 1'b0;
        CacheWD        = WD;
        ANew           = A;
        ActiveByteMask = ByteMask;
        CacheRDSel     = A[WORD_OFFSET+1:WORD_OFFSET];
        BusAdr         = {A[31:BLOCK_OFFSET], cnt, 2'b00};
        BusWD          = victim_rd;
        BusRE          = 1'b0;
        BusWE          = 1'b0;

        unique case (state)
            READY: begin
                if (req && hit) begin
                    if (MemWE) begin
                        W1WE    = w1hit;
                        W2WE    = !w1hit;
                        DirtyIn = 1'b1;
                    end
                end else if (req) begin
                    Stall       = 1'b1;
                    victim_next = miss_victim;
                    cnt_next    = 2'd0;
                    state_next  = miss_victim_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                Stall      = 1'b1;
                ANew       = {A[31:BLOCK_OFFSET], cnt, 2'b00};
                CacheRDSel = cnt;
                BusWE      = 1'b1;
                BusAdr     = {victim_tag, set, cnt, 2'b00};
                if (BusReady) begin
                    cnt_next = cnt + 2'd1;
                    if (last_beat) state_next = FETCH;
                end
            end
            FETCH: begin
                Stall          = 1'b1;
                BusRE          = 1'b1;
                ANew           = {A[31:BLOCK_OFFSET], cnt, 2'b00};
                ActiveByteMask = 4'hF;
                CacheWD        = BusRD;
                if (BusReady) begin
                    W1WE     = !victim;
                    W2WE     = victim;
                    cnt_next = cnt + 2'd1;
                    if (last_beat) state_next = READY;
                end
            end
            default: state_next = READY;
        endcase

        // Reset abandons any transfer immediately, without waiting for the edge.
        if (reset) begin
            Stall = 1'b0;
            W1WE  = 1'b0;
            W2WE  = 1'b0;
            BusRE = 1'b0;
            BusWE = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_writeback_associative_cache_controller.sv
// Directed bench for the data-cache miss controller; the bench plays the
// cache memory array and the external bus by driving way status directly.
module tb_data_writeback_associative_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, WD, RD;
    logic        MemRE, MemWE, Stall;
    logic [3:0]  ByteMask, ActiveByteMask;
    logic        W1V, W2V, W1D, W2D, CurrLRU;
    logic [13:0] W1Tag, W2Tag;
    logic [31:0] W1RD, W2RD, CacheWD, ANew, BusAdr, BusWD, BusRD;
    logic        W1WE, W2WE, DirtyIn, BusRE, BusWE, BusReady;
    logic [1:0]  CacheRDSel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_writeback_associative_cache_controller dut (
        .clk(clk), .reset(reset), .A(A), .MemRE(MemRE), .MemWE(MemWE),
        .WD(WD), .ByteMask(ByteMask), .RD(RD), .Stall(Stall),
        .W1V(W1V), .W2V(W2V), .W1D(W1D), .W2D(W2D), .CurrLRU(CurrLRU),
        .W1Tag(W1Tag), .W2Tag(W2Tag), .W1RD(W1RD), .W2RD(W2RD),
        .W1WE(W1WE), .W2WE(W2WE), .DirtyIn(DirtyIn), .CacheWD(CacheWD),
        .ANew(ANew), .ActiveByteMask(ActiveByteMask), .CacheRDSel(CacheRDSel),
        .BusAdr(BusAdr), .BusWD(BusWD), .BusRE(BusRE), .BusWE(BusWE),
        .BusRD(BusRD), .BusReady(BusReady)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; A = 32'h0000_1008; MemRE = 1'b0; MemWE = 1'b1;
        WD = 32'h0; ByteMask = 4'hF; W1V = 1'b1; W2V = 1'b0; W1D = 1'b0;
        W2D = 1'b0; CurrLRU = 1'b0; W1Tag = 14'd0; W2Tag = 14'd0;
        W1RD = 32'h0; W2RD = 32'h0; BusRD = 32'h0; BusReady = 1'b0;
        tick(); tick();
        #3;
        n_checks++;
        if ({W1WE, W2WE, BusRE, BusWE, Stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000", {W1WE, W2WE, BusRE, BusWE, Stall});
        end
        reset = 1'b0; MemWE = 1'b0; W1V = 1'b0;
        tick();
        #3;
        n_checks++;
        if ({Stall, BusRE, BusWE} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 000", {Stall, BusRE, BusWE});
        end
    endtask

    task automatic test_read_miss();
        A = 32'h0000_1004; MemRE = 1'b1; W1V = 1'b0; W2V = 1'b0; BusReady = 1'b1;
        #3;
        n_checks++;
        if ({Stall, BusRE, BusWE, W1WE} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rmiss_detect: got %b want 1000", {Stall, BusRE, BusWE, W1WE});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            BusRD = 32'hA0 + i;
            #3;
            n_checks++;
            if ({Stall, BusRE, BusWE, W1WE, W2WE, DirtyIn} !== 6'b110100 ||
                BusAdr !== 32'h1000 + 4 * i || ANew !== 32'h1000 + 4 * i ||
                CacheWD !== 32'hA0 + i || ActiveByteMask !== 4'hF) begin
                n_fail++;
                $display("FAIL rmiss_beat%0d: ctl=%b adr=%h anew=%h wd=%h bm=%h want 110100 %h %h %h f",
                         i, {Stall, BusRE, BusWE, W1WE, W2WE, DirtyIn}, BusAdr, ANew, CacheWD,
                         ActiveByteMask, 32'h1000 + 4 * i, 32'h1000 + 4 * i, 32'hA0 + i);
            end
            tick();
        end
        W1V = 1'b1; W1Tag = 14'd0; W1RD = 32'hA1;
        #3;
        n_checks++;
        if (RD !== 32'hA1 || {Stall, BusRE, W1WE} !== 3'b000 || CacheRDSel !== 2'd1) begin
            n_fail++;
            $display("FAIL rmiss_hit: rd=%h ctl=%b sel=%0d want a1 000 1", RD, {Stall, BusRE, W1WE}, CacheRDSel);
        end
        MemRE = 1'b0; BusReady = 1'b0;
        tick();
    endtask

    task automatic test_store_hit();
        A = 32'h0000_1008; MemWE = 1'b1; WD = 32'hDEADBEEF; ByteMask = 4'b0011;
        #3;
        n_checks++;
        if ({W1WE, W2WE, DirtyIn, Stall, BusRE, BusWE} !== 6'b101000 ||
            CacheWD !== 32'hDEADBEEF || ActiveByteMask !== 4'b0011 ||
            ANew !== 32'h1008 || CacheRDSel !== 2'd2) begin
            n_fail++;
            $display("FAIL store_hit: ctl=%b wd=%h bm=%b anew=%h sel=%0d want 101000 deadbeef 0011 1008 2",
                     {W1WE, W2WE, DirtyIn, Stall, BusRE, BusWE}, CacheWD, ActiveByteMask, ANew, CacheRDSel);
        end
        tick();
        #3;
        n_checks++;
        if ({Stall, BusRE, BusWE} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_hit_stay: got %b want 000", {Stall, BusRE, BusWE});
        end
        MemWE = 1'b0;
        tick();
    endtask

    task automatic test_dirty_conflict();
        W1V = 1'b1; W2V = 1'b1; W1Tag = 14'd0; W2Tag = 14'd1; W1D = 1'b1; W2D = 1'b0;
        CurrLRU = 1'b1; A = 32'h0008_1000; MemRE = 1'b1; BusReady = 1'b1;
        #3;
        n_checks++;
        if ({Stall, BusRE, BusWE} !== 3'b100) begin
            n_fail++;
            $display("FAIL dmiss_detect: got %b want 100", {Stall, BusRE, BusWE});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            W1RD = 32'h0BAD_0000 + i;
            #3;
            n_checks++;
            if ({Stall, BusWE, BusRE, W1WE, W2WE} !== 5'b11000 ||
                BusAdr !== 32'h1000 + 4 * i || BusWD !== 32'h0BAD_0000 + i ||
                CacheRDSel !== 2'(i)) begin
                n_fail++;
                $display("FAIL dmiss_wb%0d: ctl=%b adr=%h wd=%h sel=%0d want 11000 %h %h %0d",
                         i, {Stall, BusWE, BusRE, W1WE, W2WE}, BusAdr, BusWD, CacheRDSel,
                         32'h1000 + 4 * i, 32'h0BAD_0000 + i, i);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            BusRD = 32'hC0 + i;
            #3;
            n_checks++;
            if ({Stall, BusRE, BusWE, W1WE, W2WE, DirtyIn} !== 6'b110100 ||
                BusAdr !== 32'h8_1000 + 4 * i || CacheWD !== 32'hC0 + i) begin
                n_fail++;
                $display("FAIL dmiss_fetch%0d: ctl=%b adr=%h wd=%h want 110100 %h %h",
                         i, {Stall, BusRE, BusWE, W1WE, W2WE, DirtyIn}, BusAdr, CacheWD,
                         32'h8_1000 + 4 * i, 32'hC0 + i);
            end
            tick();
        end
        W1Tag = 14'd2; W1D = 1'b0; W1RD = 32'hC0;
        #3;
        n_checks++;
        if (Stall !== 1'b0 || RD !== 32'hC0) begin
            n_fail++;
            $display("FAIL dmiss_hit: stall=%b rd=%h want 0 c0", Stall, RD);
        end
        MemRE = 1'b0; BusReady = 1'b0;
        tick();
    endtask

    task automatic test_clean_victim();
        W1V = 1'b1; W2V = 1'b1; W1Tag = 14'd2; W2Tag = 14'd1; W1D = 1'b1; W2D = 1'b0;
        CurrLRU = 1'b0; A = 32'h000C_1000; MemRE = 1'b1; BusReady = 1'b1; BusRD = 32'h55;
        tick();
        for (int i = 0; i < 4; i++) begin
            #3;
            n_checks++;
            if ({BusRE, BusWE, W1WE, W2WE} !== 4'b1001 || BusAdr !== 32'hC_1000 + 4 * i) begin
                n_fail++;
                $display("FAIL clean_fetch%0d: ctl=%b adr=%h want 1001 %h",
                         i, {BusRE, BusWE, W1WE, W2WE}, BusAdr, 32'hC_1000 + 4 * i);
            end
            tick();
        end
        W2Tag = 14'd3; W2RD = 32'h55;
        #3;
        n_checks++;
        if (Stall !== 1'b0 || RD !== 32'h55 || BusRE !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_hit: stall=%b rd=%h bre=%b want 0 55 0", Stall, RD, BusRE);
        end
        MemRE = 1'b0; BusReady = 1'b0;
        tick();
    endtask

    task automatic test_bus_wait();
        W1V = 1'b0; W2V = 1'b1; A = 32'h0010_1000; MemRE = 1'b1; BusReady = 1'b1;
        tick();
        tick();
        BusReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if ({Stall, BusRE, W1WE, W2WE} !== 4'b1100 || BusAdr !== 32'h10_1004) begin
                n_fail++;
                $display("FAIL wait_hold%0d: ctl=%b adr=%h want 1100 00101004",
                         i, {Stall, BusRE, W1WE, W2WE}, BusAdr);
            end
            tick();
        end
        BusReady = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #3;
            n_checks++;
            if ({BusRE, W1WE} !== 2'b11 || BusAdr !== 32'h10_1000 + 4 * i) begin
                n_fail++;
                $display("FAIL wait_resume%0d: ctl=%b adr=%h want 11 %h",
                         i, {BusRE, W1WE}, BusAdr, 32'h10_1000 + 4 * i);
            end
            tick();
        end
        MemRE = 1'b0; BusReady = 1'b0;
        #3;
        n_checks++;
        if ({Stall, BusRE} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_done: got %b want 00", {Stall, BusRE});
        end
        tick();
    endtask

    task automatic test_reset_mid_writeback();
        W1V = 1'b1; W2V = 1'b1; W1Tag = 14'd0; W2Tag = 14'd1; W1D = 1'b1; W2D = 1'b0;
        CurrLRU = 1'b1; A = 32'h0014_1000; MemRE = 1'b1; BusReady = 1'b1;
        tick();
        tick();
        tick();
        BusReady = 1'b0;
        #1;
        n_checks++;
        if ({BusWE, BusAdr} !== {1'b1, 32'h0000_1008}) begin
            n_fail++;
            $display("FAIL rst_wb_beat2: bwe=%b adr=%h want 1 00001008", BusWE, BusAdr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({Stall, BusRE, BusWE, W1WE, W2WE} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_wb_strobes: got %b want 00000", {Stall, BusRE, BusWE, W1WE, W2WE});
        end
        tick();
        reset = 1'b0; MemRE = 1'b0;
        #3;
        n_checks++;
        if ({Stall, BusRE, BusWE} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_wb_idle: got %b want 000", {Stall, BusRE, BusWE});
        end
        MemRE = 1'b1;
        #1;
        n_checks++;
        if ({Stall, BusRE, BusWE} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_wb_ready: got %b want 100", {Stall, BusRE, BusWE});
        end
        MemRE = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_store_hit();
        test_dirty_conflict();
        test_clean_victim();
        test_bus_wait();
        test_reset_mid_writeback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
